adc_sequencer: RTL and testbench

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_seq_pkg.sv | 45 ++++
 rtl/sample_fifo.sv | 75 +++++++
 rtl/adc_sequencer.sv | 141 ++++++++++++++
 tb/tb_adc_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg -- shared constants, sample type and channel-selection helper
// for the ADC sequencer.
//
// Contents:
//   NUM_CH, ADC_DW, CH_W, SMP_W : channel count, ADC word width, channel tag
//                                 width, packed sample width
//   sample_t                    : packed {channel, data} sample word
//   next_channel()              : lowest enabled channel above cur, wrapping

package adc_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int ADC_DW = 12;
    localparam int CH_W   = 2;
    localparam int SMP_W  = CH_W + ADC_DW;

    typedef struct packed {
        logic [CH_W-1:0]   channel;
        logic [ADC_DW-1:0] data;
    } sample_t;

    // Scans cur+1, cur+2, ... modulo NUM_CH and returns the first enabled
    // index. The last candidate is cur itself, so a single-bit mask keeps
    // selecting the same channel. Returns cur when the mask is empty; the
    // caller handles that case separately.
    function automatic logic [CH_W-1:0] next_channel(
        input logic [NUM_CH-1:0] mask,
        input logic [CH_W-1:0]   cur
    );
        logic [CH_W-1:0] result;
        logic [CH_W-1:0] idx;
        logic            found;
        result = cur;
        found  = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur + i[CH_W-1:0];
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo -- synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data; ignored when full unless pop is accepted
//                in the same cycle
//   push_data  : word to write
//   pop        : remove the head word; ignored when empty
//   pop_data   : current head word (zero while empty); a word written into
//                an empty FIFO becomes visible the cycle after the push
//   full/empty : occupancy flags
//
// DEPTH must be a power of two (pointers wrap by overflow), minimum 2.

module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // where wr_ptr points, so the write can be accepted.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer -- round-robin ADC channel sequencer with tagged sample FIFO.
//
// A free-running frame counter (0..FRAME_LEN-1) paces ADC conversions. At
// the last count of each frame the enable mask is sampled and the next
// enabled channel is registered onto adc_addr. The conversion result for
// the address issued in frame N is returned in frame N+1 and captured at
// count 0 of frame N+2, so a two-deep tag pipeline (issued, pending) keeps
// each captured word paired with the channel that produced it.
//
// Ports:
//   clk        : clock (also the ADC serial clock)
//   rst_n      : asynchronous active-low reset
//   ch_en      : per-channel enable mask, sampled once per frame
//   adc_data   : conversion word from the ADC interface
//   adc_addr   : channel address driven to the ADC interface
//   smp_valid  : sample available (FIFO non-empty)
//   smp_ready  : consumer accepts the sample
//   smp_data   : sample value
//   smp_ch     : channel tag of smp_data
//   drop_cnt   : saturating count of samples dropped on a full FIFO
//                (only present when ADC_SEQ_DROP_CNT_EN is defined)
//
// Handshake: a sample transfers, and the FIFO pops, exactly on a cycle
// where smp_valid && smp_ready; while smp_valid is high and smp_ready is
// low, smp_data/smp_ch hold their value.
//
// Build option: define ADC_SEQ_DROP_CNT_EN to add the drop_cnt port.

module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ch_en,
    input  logic [11:0] adc_data,
    output logic [1:0]  adc_addr,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [11:0] smp_data,
    output logic [1:0]  smp_ch
`ifdef ADC_SEQ_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int                FCNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

    logic [FCNT_W-1:0] fcnt;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   nxt_ch;
    logic              iss_vld;
    logic [CH_W-1:0]   iss_ch;
    logic              pnd_vld;
    logic [CH_W-1:0]   pnd_ch;
    logic              frame_end;
    logic              capture;

    logic              push_req;
    logic              push_acc;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    sample_t           push_smp;
    sample_t           head_smp;

    assign frame_end = (fcnt == FCNT_LAST);
    assign capture   = (fcnt == '0);
    assign nxt_ch    = next_channel(ch_en, cur_ch);

    // Frame counter, channel selection and tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            cur_ch   <= CH_W'(NUM_CH - 1);
            adc_addr <= '0;
            iss_vld  <= 1'b0;
            iss_ch   <= '0;
            pnd_vld  <= 1'b0;
            pnd_ch   <= '0;
        end else begin
            fcnt <= frame_end ? '0 : fcnt + 1'b1;
            if (frame_end) begin
                pnd_vld <= iss_vld;
                pnd_ch  <= iss_ch;
                if (ch_en == '0) begin
                    // Nothing enabled: keep the address, issue an untagged frame.
                    iss_vld <= 1'b0;
                end else begin
                    cur_ch   <= nxt_ch;
                    adc_addr <= nxt_ch;
                    iss_vld  <= 1'b1;
                    iss_ch   <= nxt_ch;
                end
            end
        end
    end

    assign push_req = capture && pnd_vld;
    assign push_smp = {pnd_ch, adc_data};
    assign pop      = smp_valid && smp_ready;
    // A push onto a full FIFO survives only if the head leaves this cycle.
    assign push_acc = push_req && (!fifo_full || pop);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SMP_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_acc),
        .push_data (push_smp),
        .pop       (pop),
        .pop_data  (head_smp),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign smp_valid = !fifo_empty;
    assign smp_data  = head_smp.data;
    assign smp_ch    = head_smp.channel;

`ifdef ADC_SEQ_DROP_CNT_EN
    logic drop;

    assign drop = push_req && !push_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer -- bench for adc_sequencer.
//
// A frame-level reference model runs on the clock: it tracks the frame
// position, picks channels from the sampled mask, keeps a queue of issued
// tags (a capture uses the tag issued two frame boundaries earlier) and a
// bounded occupancy count. Accepted samples go to exp_q; a monitor on the
// falling edge compares every presented sample against the queue head and
// pops it on transfer. Inputs change 2 time units after the rising edge.

module tb_adc_sequencer;

    localparam int FRAME_LEN  = 16;
    localparam int FIFO_DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  ch_en     = 4'b0000;
    logic [11:0] adc_data  = 12'h000;
    logic        smp_ready = 1'b0;
    logic [1:0]  adc_addr;
    logic        smp_valid;
    logic [11:0] smp_data;
    logic [1:0]  smp_ch;
`ifdef ADC_SEQ_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    adc_sequencer #(
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .adc_data  (adc_data),
        .adc_addr  (adc_addr),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .smp_ch    (smp_ch)
`ifdef ADC_SEQ_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_fcnt  = 0;
    int          m_cur   = 3;
    int          m_addr  = 0;
    int          m_occ   = 0;
    int          m_drops = 0;
    int          m_tag;
    int          m_nxt;
    bit          m_pop;
    int          tag_q[$];
    logic [13:0] exp_q[$];

    task automatic model_reset();
        m_fcnt  = 0;
        m_cur   = 3;
        m_addr  = 0;
        m_occ   = 0;
        m_drops = 0;
        tag_q.delete();
        tag_q.push_back(-1);  // pending tag after reset
        tag_q.push_back(-1);  // issued tag after reset
        exp_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pop = (m_occ > 0) && smp_ready;
            if (m_fcnt == 0) begin
                m_tag = tag_q.pop_front();
                if (m_tag >= 0) begin
                    if (m_occ == FIFO_DEPTH && !m_pop) begin
                        m_drops++;
                    end else begin
                        exp_q.push_back({m_tag[1:0], adc_data});
                        m_occ++;
                    end
                end
            end
            if (m_pop) m_occ--;
            if (m_fcnt == FRAME_LEN - 1) begin
                m_nxt = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (m_nxt < 0 && ch_en[(m_cur + k) % 4]) m_nxt = (m_cur + k) % 4;
                end
                if (m_nxt < 0) begin
                    tag_q.push_back(-1);
                end else begin
                    m_cur  = m_nxt;
                    m_addr = m_nxt;
                    tag_q.push_back(m_nxt);
                end
                m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", smp_valid, 0);
            chk("rst_addr", adc_addr, 0);
            chk("rst_data", {smp_ch, smp_data}, 0);
`ifdef ADC_SEQ_DROP_CNT_EN
            chk("rst_drop_cnt", drop_cnt, 0);
`endif
        end else begin
            chk("valid", smp_valid, m_occ > 0);
            chk("addr", adc_addr, m_addr);
            if (smp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample actual=%0h required=none at %0t",
                             {smp_ch, smp_data}, $time);
                end else begin
                    chk("sample", {smp_ch, smp_data}, exp_q[0]);
                    if (smp_ready) void'(exp_q.pop_front());
                end
            end
`ifdef ADC_SEQ_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    bit rand_data = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_data) adc_data = 12'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic frames(input int n);
        run(n * FRAME_LEN);
    endtask

    task automatic wait_fcnt(input int v);
        for (int i = 0; i < FRAME_LEN && m_fcnt != v; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_now_valid", smp_valid, 0);
        chk("rst_now_addr", adc_addr, 0);
        run(2);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // single channel, constant data
        ch_en     = 4'b0001;
        adc_data  = 12'hABC;
        smp_ready = 1'b1;
        run(3);
        rst_n = 1'b1;
        frames(6);

        // sequence 0,1,3 with random data
        rand_data = 1'b1;
        ch_en     = 4'b1011;
        frames(8);

        // mask change mid-frame takes effect only at frame end
        ch_en = 4'b0001;
        frames(2);
        wait_fcnt(5);
        ch_en = 4'b0100;
        frames(4);

        // backpressure long enough to overflow, then drain
        ch_en     = 4'b1111;
        smp_ready = 1'b0;
        frames(8);
        smp_ready = 1'b1;
        frames(3);

        // empty mask, then a single channel
        ch_en = 4'b0000;
        frames(3);
        ch_en = 4'b0010;
        frames(4);

        // reset with three samples buffered, mid-frame
        ch_en     = 4'b0001;
        smp_ready = 1'b0;
        do_reset();
        frames(4);
        wait_fcnt(7);
        chk("pre_reset_valid", smp_valid, 1);
        do_reset();
        ch_en     = 4'b0000;
        smp_ready = 1'b1;
        frames(3);

        // random traffic
        ch_en = 4'b1111;
        for (int i = 0; i < 30 * FRAME_LEN; i++) begin
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom_range(0, 15));
            smp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // drain
        ch_en     = 4'b0000;
        smp_ready = 1'b1;
        frames(4);
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
